// File: rtl/fft_bitrev_reader_pkg.sv
// Shared definitions for the FFT reorder path: default block geometry and the
// bit-reversal helper also used by the FFT core's address generator.
package fft_bitrev_reader_pkg;

  localparam int unsigned SIZE_BITS_ADDRES = 4;
  localparam int unsigned N                = 2 ** SIZE_BITS_ADDRES;

  // Widest address the helper supports; callers cast the result down to their width.
  localparam int unsigned MaxAddrBits = 16;

  // Reverses the low `width` bits of addr; bits above `width` come back as zero.
  function automatic logic [MaxAddrBits-1:0] bitrev(input logic [MaxAddrBits-1:0] addr,
                                                    input int unsigned           width);
    logic [MaxAddrBits-1:0] rev;
    rev = {<<{addr}};
    return rev >> (MaxAddrBits - width);
  endfunction

endpackage

// File: rtl/fft_bank_pair.sv
// Two N-deep RAM banks sharing one write port and one registered read port.
// The read register doubles as the reorder buffer's output data register.
module fft_bank_pair #(
  parameter int unsigned Width    = 16,
  parameter int unsigned AddrBits = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic                wr_bank_i,
  input  logic [AddrBits-1:0] wr_addr_i,
  input  logic [Width-1:0]    wr_data_i,
  input  logic                rd_en_i,
  input  logic                rd_bank_i,
  input  logic [AddrBits-1:0] rd_addr_i,
  output logic [Width-1:0]    rd_data_o
);

  localparam int unsigned Depth = 2 ** AddrBits;

  logic [Width-1:0] mem0_q [Depth];
  logic [Width-1:0] mem1_q [Depth];
  logic [Width-1:0] rd_data_q, rd_data_d;

  // Contents are never reset so the arrays can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !wr_bank_i) mem0_q[wr_addr_i] <= wr_data_i;
    if (wr_en_i && wr_bank_i)  mem1_q[wr_addr_i] <= wr_data_i;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = rd_bank_i ? mem1_q[rd_addr_i] : mem0_q[rd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reader.sv
// Ping-pong reorder buffer: blocks are written in natural order into one bank while
// the other bank is streamed out in bit-reversed address order.
module fft_bitrev_reader
  import fft_bitrev_reader_pkg::*;
#(
  parameter int unsigned DATA_FFT_SIZE    = 16,
  parameter int unsigned SIZE_BITS_ADDRES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_FFT_SIZE-1:0]    in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_FFT_SIZE-1:0]    out_data,
  output logic                        out_last,
  output logic [SIZE_BITS_ADDRES-1:0] out_index
);

  localparam logic [SIZE_BITS_ADDRES-1:0] CntMax = '1;
  localparam logic [SIZE_BITS_ADDRES-1:0] CntOne = SIZE_BITS_ADDRES'(1);

  logic                        wr_bank_q, wr_bank_d;
  logic [SIZE_BITS_ADDRES-1:0] wr_cnt_q, wr_cnt_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [SIZE_BITS_ADDRES-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]                  full_q, full_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [SIZE_BITS_ADDRES-1:0] out_index_q, out_index_d;

  logic                        wr_fire;
  logic                        rd_issue;
  logic [SIZE_BITS_ADDRES-1:0] rd_addr;

  always_comb begin
    in_ready    = !full_q[wr_bank_q];
    wr_fire     = in_valid && in_ready;
    rd_issue    = full_q[rd_bank_q] && (!out_valid_q || out_ready);
    rd_addr     = SIZE_BITS_ADDRES'(bitrev(MaxAddrBits'(rd_cnt_q), SIZE_BITS_ADDRES));

    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;

    // Clear before set: if both hit the same bank the set must win.
    if (rd_issue) begin
      rd_cnt_d    = rd_cnt_q + CntOne;
      out_valid_d = 1'b1;
      out_index_d = rd_cnt_q;
      out_last_d  = (rd_cnt_q == CntMax);
      if (rd_cnt_q == CntMax) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + CntOne;
      if (wr_cnt_q == CntMax) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
    end
  end

  fft_bank_pair #(
    .Width    (DATA_FFT_SIZE),
    .AddrBits (SIZE_BITS_ADDRES)
  ) u_banks (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_fire),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (in_data),
    .rd_en_i   (rd_issue),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Directed bench for fft_bitrev_reader: N=16 instance plus a small N=2 instance.
module tb_fft_bitrev_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] in_data, out_data;
  logic [3:0]  out_index;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [15:0] in_data2, out_data2;
  logic [0:0]  out_index2;

  always #5 clk = ~clk;

  fft_bitrev_reader #(.DATA_FFT_SIZE(16), .SIZE_BITS_ADDRES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_index(out_index)
  );

  fft_bitrev_reader #(.DATA_FFT_SIZE(16), .SIZE_BITS_ADDRES(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .out_index(out_index2)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int sent_total = 0;
  int inr_low = 0;
  logic acc_flag;

  // Hand-computed 4-bit bit-reversal of 0..15.
  int rev16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [15:0] obs_data [$];
  logic [3:0]  obs_idx  [$];
  logic        obs_last [$];
  int          obs_cyc  [$];
  logic        obs_inr  [$];

  logic [15:0] n2_data [$];
  logic        n2_idx  [$];
  logic        n2_last [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete(); obs_idx.delete(); obs_last.delete(); obs_cyc.delete();
    obs_inr.delete();
  endtask

  // One clock: drive, sample at the falling edge, then step past the rising edge.
  task automatic tick(input logic iv, input logic [15:0] id, input logic ordy);
    in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
    acc_flag = iv && (in_ready === 1'b1);
    if (acc_flag) last_acc_cyc = cyc;
    if (iv && in_ready !== 1'b1) inr_low++;
    if (out_valid === 1'b1 && ordy) begin
      obs_data.push_back(out_data); obs_idx.push_back(out_index);
      obs_last.push_back(out_last); obs_cyc.push_back(cyc); obs_inr.push_back(in_ready);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // rmode: 0 = out_ready high, 1 = random, 2 = out_ready low.
  task automatic run(input int n_in, input logic [15:0] base, input int rmode,
                     input int want_out, input int max_ticks);
    int sent = 0;
    int t = 0;
    while ((sent < n_in || obs_data.size() < want_out) && t < max_ticks) begin
      logic ordy;
      ordy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom % 2) : 1'b0;
      tick(sent < n_in, base + sent[15:0], ordy);
      if (acc_flag) sent++;
      t++;
    end
    sent_total = sent;
  endtask

  task automatic check_block(input string tag, input logic [15:0] base, input int nblk);
    check({tag, "_count"}, obs_data.size(), nblk * 16);
    for (int k = 0; k < nblk * 16; k++) begin
      if (k < obs_data.size()) begin
        int b = k / 16;
        int j = k % 16;
        check($sformatf("%s_data%0d", tag, k), obs_data[k], base + 16 * b + rev16[j]);
        check($sformatf("%s_idx%0d", tag, k), obs_idx[k], j);
        check($sformatf("%s_last%0d", tag, k), obs_last[k], j == 15);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b0, 16'h0, 1'b1);
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_data", out_data, 0);

    // Single block, latency of two cycles after the last input
    run(16, 16'd0, 0, 16, 60);
    check_block("single", 16'd0, 1);
    if (obs_cyc.size() > 0) check("single_latency", obs_cyc[0] - last_acc_cyc, 2);

    // Back-to-back blocks with no output gap and no input stall
    do_reset();
    inr_low = 0;
    run(32, 16'd16, 0, 32, 120);
    check_block("b2b", 16'd16, 2);
    check("b2b_in_ready_low", inr_low, 0);
    if (obs_cyc.size() == 32) begin
      check("b2b_gap", obs_cyc[16] - obs_cyc[15], 1);
      check("b2b_span", obs_cyc[31] - obs_cyc[0], 31);
    end

    // Backpressure: both banks fill, then drain
    do_reset();
    run(48, 16'd0, 2, 0, 40);
    check("bp_accepted", sent_total, 32);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 0);
    clear_obs();
    run(16, 16'd32, 0, 48, 300);
    check_block("bp", 16'd0, 3);
    if (obs_inr.size() > 15) begin
      check("bp_in_ready_at14", obs_inr[14], 0);
      check("bp_in_ready_at15", obs_inr[15], 1);
    end

    // Random out_ready over 8 blocks
    do_reset();
    run(128, 16'd0, 1, 128, 2000);
    check_block("rnd", 16'd0, 8);

    // Reset in the middle of a block
    do_reset();
    run(7, 16'd50, 0, 0, 7);
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b1);
    rst = 1'b0;
    check("mid_in_ready", in_ready, 1);
    check("mid_out_valid", out_valid, 0);
    clear_obs();
    run(16, 16'd100, 0, 16, 60);
    check_block("mid", 16'd100, 1);

    // N=2 instance: bitrev is the identity
    check("n2_in_ready", in_ready2, 1);
    in_valid2 = 1'b1; in_data2 = 16'd5; out_ready2 = 1'b1;
    @(posedge clk); #1;
    in_data2 = 16'd6;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid2 === 1'b1) begin
        n2_data.push_back(out_data2); n2_idx.push_back(out_index2);
        n2_last.push_back(out_last2);
      end
      @(posedge clk); #1;
    end
    check("n2_count", n2_data.size(), 2);
    if (n2_data.size() == 2) begin
      check("n2_data0", n2_data[0], 5);
      check("n2_data1", n2_data[1], 6);
      check("n2_idx0", n2_idx[0], 0);
      check("n2_idx1", n2_idx[1], 1);
      check("n2_last0", n2_last[0], 0);
      check("n2_last1", n2_last[1], 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reader.md
Name: fft_bitrev_reader

Overview:
- Ping-pong reorder buffer at the FFT output.
- Accepts one block of 2**SIZE_BITS_ADDRES samples in natural write order and streams the block out in bit-reversed address order, with valid/ready flow control on both sides.
- Two internal banks let the upstream write block k+1 while the downstream drains block k.

Parameters:
DATA_FFT_SIZE, 16, sample width in bits (packed re/im).
SIZE_BITS_ADDRES, 4, log2 of block length N; each bank holds N words.

Ports:
clk  input  1  sole clock, all logic on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream sample valid.
in_ready  output  1  buffer can accept a sample.
in_data  input  DATA_FFT_SIZE  upstream sample.
out_valid  output  1  out_data holds a valid sample.
out_ready  input  1  downstream accepts the sample.
out_data  output  DATA_FFT_SIZE  reordered sample.
out_last  output  1  high with the final sample (index N-1) of a block.
out_index  output  SIZE_BITS_ADDRES  output sequence number 0..N-1 (natural order).

Behaviour:
- Storage: bank0 and bank1, each N x DATA_FFT_SIZE. Synchronous write. Synchronous read with enable; the read register is the output register.
- Write side:
  - wr_bank (1 bit) and wr_cnt (SIZE_BITS_ADDRES bits).
  - in_ready = !full[wr_bank].
  - On in_valid & in_ready: bank[wr_bank][wr_cnt] <= in_data, then wr_cnt++.
  - When wr_cnt == N-1 on a write: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Read side:
  - rd_bank and rd_cnt.
  - rd_issue = full[rd_bank] & (!out_valid | out_ready).
  - On rd_issue:
    - out_data <= bank[rd_bank][bitrev(rd_cnt)]
    - out_index <= rd_cnt
    - out_last <= (rd_cnt == N-1)
    - out_valid <= 1
    - rd_cnt++
  - On the issue with rd_cnt == N-1: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
  - If out_valid & out_ready & !rd_issue: out_valid <= 0. out_data, out_index and out_last hold their values.
  - While out_valid & !out_ready, out_data, out_index and out_last are stable.
- bitrev: bit i of the address equals bit (SIZE_BITS_ADDRES-1-i) of rd_cnt.
- Latency: the last input handshake at cycle T produces out_valid=1 at T+2, with sample index 0. After that, one sample per cycle while out_ready=1. No bubbles between consecutive full banks.
- Simultaneous events:
  - The same cycle can set full[wr_bank] and clear full[rd_bank] when the banks differ. Both take effect.
  - If rd_bank == wr_bank, the bank is empty, so no read issues and the set wins.
  - The writer never writes a full bank, so there is no read/write collision on one bank.
- Both banks full: in_ready=0 until the last read of rd_bank is issued. in_ready returns 1 the following cycle.
- Reset (any time, including mid-block):
  - wr_cnt, rd_cnt, wr_bank, rd_bank, full[1:0] <= 0.
  - out_valid, out_last <= 0; out_data, out_index <= 0.
  - Memory contents are not cleared; partial blocks are discarded.
  - After reset: in_ready=1.
- The block is N-generic. N=2 (SIZE_BITS_ADDRES=1) must work; there bitrev is the identity.

Decomposition:
- Shared package: a bitrev function parameterised by width, and a localparam N = 2**SIZE_BITS_ADDRES. The FFT core's address generator reuses both.
- One sub-module: fft_bank_pair, two N-deep synchronous-read RAMs with independent write/read ports and read enable, mapped to block RAM.
- Control (counters, full flags, output stage) stays in the top module.

Test Plan:
- Single block, N=16: in_data 0..15 back-to-back, out_ready=1 -> out_data 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. out_index 0..15. out_last only on the sample 15. First out_valid 2 cycles after the last input.
- Back-to-back blocks: 0..15 then 16..31, continuous -> second block output is 16,24,20,...,31. out_valid has no gap between the blocks. in_ready stays 1 throughout.
- Backpressure: out_ready=0 while 3 blocks are offered. Expect:
  - in_ready falls after 32 accepted samples.
  - out_data holds 0 with out_valid=1.
  - Raising out_ready drains 32 samples in order; in_ready rises one cycle after the issue of the 16th read.
- Random out_ready (50%) over 8 blocks with in_data = running count -> the scoreboard matches the bitrev sequence. No drop, no duplicate; out_last is on every 16th accepted output.
- Reset mid-block: 7 samples written, rst pulsed 1 cycle -> the next cycle has in_ready=1 and out_valid=0. The next 16 inputs 100..115 produce 100,108,104,...,115.
- N=2 build: inputs 5,6 -> outputs 5,6, with out_last on 6.
